// File: rtl/matrix_unary_engine_pkg.sv
// rtl/matrix_unary_engine_pkg.sv - shared matrix op encodings and element helpers
package matrix_pkg;

  typedef enum logic [1:0] {
    OP_NEG       = 2'd0,
    OP_NEG_SAT   = 2'd1,
    OP_TRANSPOSE = 2'd2,
    OP_SCALE     = 2'd3
  } op_e;

  function automatic longint elem_max(int w);
    return (longint'(1) << (w - 1)) - longint'(1);
  endfunction

  function automatic longint elem_min(int w);
    return -(longint'(1) << (w - 1));
  endfunction

  // Bit offset of element (r,c) in a packed row-major matrix.
  function automatic int pidx(int r, int c, int dim, int w);
    return (r * dim + c) * w;
  endfunction

endpackage

// File: rtl/matrix_unary_engine_if.sv
// rtl/matrix_unary_engine_if.sv - request/result bundle of the unary matrix engine
interface matrix_unary_engine_if
  import matrix_pkg::*;
#(
  parameter int DIM = 5,
  parameter int W   = 8
);
  logic                   start;
  op_e                    op;
  logic [W-1:0]           scalar;
  logic [DIM*DIM*W-1:0]   matrix_a;
  logic [DIM*DIM*W-1:0]   result;
  logic                   busy;
  logic                   done;
  logic                   overflow;

  modport master (
    output start, op, scalar, matrix_a,
    input  result, busy, done, overflow
  );

  modport slave (
    input  start, op, scalar, matrix_a,
    output result, busy, done, overflow
  );
endinterface

// File: rtl/matrix_unary_engine_lane_alu.sv
// rtl/matrix_unary_engine_lane_alu.sv - one element lane: negate, saturating negate, saturating scale
module matrix_lane_alu
  import matrix_pkg::*;
#(
  parameter int W = 8
) (
  input  op_e                  i_op,
  input  logic signed [W-1:0]  i_a,
  input  logic signed [W-1:0]  i_scalar,
  output logic signed [W-1:0]  o_y,
  output logic                 o_ovf
);
  localparam logic signed [W-1:0]   MINV = W'(elem_min(W));
  localparam logic signed [W-1:0]   MAXV = W'(elem_max(W));
  localparam logic signed [2*W-1:0] MIN2 = (2*W)'(elem_min(W));
  localparam logic signed [2*W-1:0] MAX2 = (2*W)'(elem_max(W));

  logic signed [2*W-1:0] w_prod;
  assign w_prod = i_a * i_scalar;

  // Transpose is a pure move, so the lane passes the element through untouched.
  always_comb begin
    o_y   = i_a;
    o_ovf = 1'b0;
    case (i_op)
      OP_NEG: begin
        o_y   = -i_a;
        o_ovf = (i_a == MINV);
      end
      OP_NEG_SAT: begin
        if (i_a == MINV) begin
          o_y   = MAXV;
          o_ovf = 1'b1;
        end else begin
          o_y = -i_a;
        end
      end
      OP_SCALE: begin
        if (w_prod > MAX2) begin
          o_y   = MAXV;
          o_ovf = 1'b1;
        end else if (w_prod < MIN2) begin
          o_y   = MINV;
          o_ovf = 1'b1;
        end else begin
          o_y = w_prod[W-1:0];
        end
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/matrix_unary_engine.sv
// rtl/matrix_unary_engine.sv - sequential LANES-wide unary matrix engine (negate, transpose, scale)
module matrix_unary_engine
  import matrix_pkg::*;
#(
  parameter int DIM   = 5,
  parameter int W     = 8,
  parameter int LANES = 5
) (
  input logic                  clk,
  input logic                  rst,
  matrix_unary_engine_if.slave bus
);
  localparam int N  = DIM * DIM;
  localparam int IW = $clog2(N + LANES + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]          r_state;
  logic [N*W-1:0]      r_a;
  op_e                 r_op;
  logic signed [W-1:0] r_scalar;
  logic [N*W-1:0]      r_result;
  logic                r_ovf;
  logic [IW-1:0]       r_idx;

  logic signed [W-1:0] w_y        [LANES];
  logic                w_lane_ovf [LANES];
  logic                w_en       [LANES];
  int                  w_dst_off  [LANES];
  logic                w_any_ovf;
  logic                w_last;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [IW-1:0]       w_e, w_ei, w_row, w_col;
    logic signed [W-1:0] w_a;

    assign w_e     = r_idx + IW'(l);
    assign w_en[l] = (w_e < IW'(N));
    assign w_ei    = w_en[l] ? w_e : '0;
    assign w_row   = w_ei / IW'(DIM);
    assign w_col   = w_ei % IW'(DIM);
    assign w_a     = r_a[pidx(int'(w_row), int'(w_col), DIM, W) +: W];
    // Transpose writes element (r,c) to slot (c,r); every other mode writes in place.
    assign w_dst_off[l] = (r_op == OP_TRANSPOSE) ? pidx(int'(w_col), int'(w_row), DIM, W)
                                                 : pidx(int'(w_row), int'(w_col), DIM, W);

    matrix_lane_alu #(.W(W)) u_alu (
      .i_op     (r_op),
      .i_a      (w_a),
      .i_scalar (r_scalar),
      .o_y      (w_y[l]),
      .o_ovf    (w_lane_ovf[l])
    );
  end

  always_comb begin
    w_any_ovf = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      w_any_ovf = w_any_ovf | (w_en[l] & w_lane_ovf[l]);
    end
  end

  assign w_last = ((r_idx + IW'(LANES)) >= IW'(N));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_op     <= OP_NEG;
      r_scalar <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_idx    <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          for (int l = 0; l < LANES; l++) begin
            if (w_en[l]) r_result[w_dst_off[l] +: W] <= w_y[l];
          end
          r_ovf <= r_ovf | w_any_ovf;
          r_idx <= r_idx + IW'(LANES);
          if (w_last) r_state <= S_DONE;
        end
        default: begin
          if (bus.start) begin
            r_a      <= bus.matrix_a;
            r_op     <= bus.op;
            r_scalar <= bus.scalar;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_idx    <= '0;
            r_state  <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.result   = r_result;
  assign bus.busy     = (r_state == S_RUN);
  assign bus.done     = (r_state == S_DONE);
  assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_matrix_unary_engine.sv
// tb/tb_matrix_unary_engine.sv - scoreboard bench for two lane configurations of the engine
module tb_matrix_unary_engine;
  import matrix_pkg::*;

  localparam int D  = 5;
  localparam int W  = 8;
  localparam int N  = D * D;
  localparam int NW = N * W;
  localparam int LA = 5;
  localparam int LB = 3;
  localparam int BA = (N + LA - 1) / LA;
  localparam int BB = (N + LB - 1) / LB;

  typedef struct {
    logic [NW-1:0] res;
    bit            ov;
    int            due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  matrix_unary_engine_if #(.DIM(D), .W(W)) ifa ();
  matrix_unary_engine_if #(.DIM(D), .W(W)) ifb ();

  matrix_unary_engine #(.DIM(D), .W(W), .LANES(LA)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  matrix_unary_engine #(.DIM(D), .W(W), .LANES(LB)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  task automatic check(string name, logic [NW-1:0] got, logic [NW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: elementwise arithmetic on ints, clamped or wrapped by the mode rules.
  task automatic model(input int op, input logic [W-1:0] sc, input logic [NW-1:0] m,
                       output logic [NW-1:0] r, output bit ov);
    int a, v, s, mx, mn;
    mx = 2 ** (W - 1) - 1;
    mn = -(2 ** (W - 1));
    s  = int'($signed(sc));
    r  = '0;
    ov = 1'b0;
    for (int i = 0; i < D; i++) begin
      for (int j = 0; j < D; j++) begin
        a = int'($signed(m[(i * D + j) * W +: W]));
        v = a;
        case (op)
          0: begin v = -a; if (v > mx) begin v = v - 2 ** W; ov = 1'b1; end end
          1: begin v = -a; if (v > mx) begin v = mx; ov = 1'b1; end end
          3: begin
            v = a * s;
            if (v > mx) begin v = mx; ov = 1'b1; end
            else if (v < mn) begin v = mn; ov = 1'b1; end
          end
          default: v = a;
        endcase
        if (op == 2) r[(j * D + i) * W +: W] = W'(v);
        else         r[(i * D + j) * W +: W] = W'(v);
      end
    end
  endtask

  function automatic logic [NW-1:0] rand_mat();
    logic [NW-1:0] m;
    for (int i = 0; i < N; i++) begin
      case ($urandom_range(0, 7))
        0:       m[i * W +: W] = 8'h80;
        1:       m[i * W +: W] = 8'h7F;
        default: m[i * W +: W] = W'($urandom);
      endcase
    end
    return m;
  endfunction

  task automatic set_in(int d, logic st, int op, logic [W-1:0] sc, logic [NW-1:0] m);
    if (d == 0) begin
      ifa.start = st; ifa.op = op_e'(op); ifa.scalar = sc; ifa.matrix_a = m;
    end else begin
      ifb.start = st; ifb.op = op_e'(op); ifb.scalar = sc; ifb.matrix_a = m;
    end
  endtask

  // Called at a negedge: presents one request and records what it must produce.
  task automatic go(int d, int op, logic [W-1:0] sc, logic [NW-1:0] m);
    exp_t e;
    model(op, sc, m, e.res, e.ov);
    e.due = cyc + 1 + ((d == 0) ? BA : BB);
    set_in(d, 1'b1, op, sc, m);
    if (d == 0) qa.push_back(e); else qb.push_back(e);
    @(negedge clk);
    set_in(d, 1'b0, int'($urandom_range(0, 3)), W'($urandom), rand_mat());
  endtask

  task automatic wait_idle(int d);
    int guard = 0;
    while (((d == 0) ? qa.size() : qb.size()) > 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check((d == 0) ? "a_timeout" : "b_timeout", 1, 0);
  endtask

  task automatic mon(int d);
    exp_t e;
    logic dn, bz, ov;
    logic [NW-1:0] res;
    int   b;
    bit   have, bexp;
    if (d == 0) begin
      dn = ifa.done; bz = ifa.busy; ov = ifa.overflow; res = ifa.result; b = BA;
      have = (qa.size() > 0); if (have) e = qa[0];
    end else begin
      dn = ifb.done; bz = ifb.busy; ov = ifb.overflow; res = ifb.result; b = BB;
      have = (qb.size() > 0); if (have) e = qb[0];
    end
    bexp = have && (cyc >= e.due - b) && (cyc < e.due);
    check((d == 0) ? "a_busy" : "b_busy", NW'(bz), NW'(bexp));
    if (dn) begin
      if (!have) begin
        check((d == 0) ? "a_unexpected_done" : "b_unexpected_done", 1, 0);
      end else begin
        check((d == 0) ? "a_result" : "b_result", res, e.res);
        check((d == 0) ? "a_overflow" : "b_overflow", NW'(ov), NW'(e.ov));
        check((d == 0) ? "a_done_cycle" : "b_done_cycle", NW'(cyc), NW'(e.due));
        if (d == 0) void'(qa.pop_front()); else void'(qb.pop_front());
      end
    end else if (have && cyc >= e.due) begin
      check((d == 0) ? "a_done_missing" : "b_done_missing", NW'(cyc), NW'(e.due));
      if (d == 0) void'(qa.pop_front()); else void'(qb.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0);
      mon(1);
    end
  end

  initial begin
    logic [NW-1:0] m;
    rst = 1'b1;
    set_in(0, 1'b1, 0, '0, '1);
    set_in(1, 1'b1, 0, '0, '1);
    repeat (3) @(negedge clk);
    check("a_rst_result", ifa.result, '0);
    check("a_rst_flags", NW'({ifa.busy, ifa.done, ifa.overflow}), '0);
    check("b_rst_result", ifb.result, '0);
    check("b_rst_flags", NW'({ifb.busy, ifb.done, ifb.overflow}), '0);
    rst = 1'b0;
    set_in(0, 1'b0, 0, '0, '0);
    set_in(1, 1'b0, 0, '0, '0);
    repeat (2) @(negedge clk);

    for (int i = 0; i < N; i++) m[i * W +: W] = 8'd1;
    m[pidx(0, 0, D, W) +: W] = 8'd5;
    m[pidx(0, 1, D, W) +: W] = 8'h80;
    go(0, 0, '0, m); wait_idle(0);
    check("a_neg_00", NW'(ifa.result[pidx(0, 0, D, W) +: W]), NW'(8'hFB));
    check("a_neg_01", NW'(ifa.result[pidx(0, 1, D, W) +: W]), NW'(8'h80));
    go(0, 1, '0, m); wait_idle(0);
    check("a_negsat_01", NW'(ifa.result[pidx(0, 1, D, W) +: W]), NW'(8'h7F));
    go(1, 0, '0, m); wait_idle(1);
    m[pidx(0, 1, D, W) +: W] = 8'd3;
    go(0, 1, '0, m); wait_idle(0);

    for (int r = 0; r < D; r++)
      for (int c = 0; c < D; c++) m[pidx(r, c, D, W) +: W] = W'(10 * r + c);
    go(0, 2, '0, m); wait_idle(0);
    check("a_tr_13", NW'(ifa.result[pidx(1, 3, D, W) +: W]), NW'(8'd31));
    go(1, 2, '0, m); wait_idle(1);

    m = '0;
    m[pidx(2, 2, D, W) +: W] = 8'd50;
    m[pidx(0, 0, D, W) +: W] = 8'd7;
    go(0, 3, 8'hFD, m); wait_idle(0);
    check("a_sc_22", NW'(ifa.result[pidx(2, 2, D, W) +: W]), NW'(8'h80));
    check("a_sc_00", NW'(ifa.result[pidx(0, 0, D, W) +: W]), NW'(8'hEB));

    // Back-to-back: second start presented in the done cycle of the first.
    go(1, 0, '0, rand_mat());
    repeat (BB) @(negedge clk);
    go(1, 3, W'($urandom), rand_mat());
    wait_idle(1);
    go(0, 1, '0, rand_mat());
    repeat (BA) @(negedge clk);
    go(0, 2, '0, rand_mat());
    wait_idle(0);

    // Start held during busy must be ignored.
    go(0, 0, '0, rand_mat());
    set_in(0, 1'b1, 3, 8'h7F, rand_mat());
    repeat (3) @(negedge clk);
    set_in(0, 1'b0, 0, '0, '0);
    wait_idle(0);
    repeat (4) @(negedge clk);

    // Reset mid-run aborts without a done pulse.
    m = rand_mat();
    m[0 +: W] = 8'h80;
    go(0, 0, '0, m);
    @(negedge clk);
    rst = 1'b1;
    qa.delete();
    @(negedge clk);
    check("a_midrst_result", ifa.result, '0);
    check("a_midrst_flags", NW'({ifa.busy, ifa.done, ifa.overflow}), '0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    go(0, 0, '0, m); wait_idle(0);

    for (int it = 0; it < 20; it++) begin
      logic [W-1:0] sc;
      sc = ($urandom_range(0, 3) == 0) ? 8'h80 : W'($urandom);
      go(it % 2, int'($urandom_range(0, 3)), sc, rand_mat());
      wait_idle(it % 2);
    end

    wait_idle(0);
    wait_idle(1);
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/matrix_unary_engine.md
# matrix_unary_engine

Sequential, parametrised successor to the combinational 5x5 matrix-opposite block of the matrix coprocessor. It latches one packed signed matrix on `start`, then processes `LANES` elements per cycle in one of four unary modes: wrapping negation, saturating negation, transpose, or saturating scalar multiply. It holds the result with a `done` pulse and a sticky overflow flag. It sits behind the coprocessor's operation decoder, beside the binary add/sub/multiply units, and shares their packed-matrix format.

## Interface
- `DIM`, 5: matrix is DIM x DIM, DIM >= 2.
- `W`, 8: signed element width, two's complement.
- `LANES`, 5: elements processed per cycle, 1..DIM*DIM.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `op`  in  2  mode: 0 = negate, wrapping; 1 = negate, saturating; 2 = transpose; 3 = scalar multiply, saturating.
- `scalar`  in  W  signed multiplier, used only when op = 3.
- `matrix_a`  in  DIM\*DIM\*W  packed, row-major: element (r,c) at `[(r*DIM+c)*W +: W]`.
- `result`  out  DIM\*DIM\*W  packed result, same layout.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse when the result is complete.
- `overflow`  out  1  sticky per operation; set if any element saturated or wrapped.

## Operation
- States:
  - IDLE: `start` moves to RUN.
  - RUN: each cycle processes one beat; after the last beat, moves to DONE.
  - DONE: `start` moves to RUN; otherwise moves to IDLE.
- On an accepted `start`: latch `matrix_a`, `op` and `scalar` into internal registers; clear `result` to 0, `overflow` to 0 and the element index `idx` to 0.
- `matrix_a`, `op` and `scalar` may change freely after the accept cycle.
- While `busy`, `start` is ignored. There is no queueing.
- Each RUN beat handles elements e = idx .. idx+LANES-1, skipping any e >= DIM\*DIM. Then idx += LANES.
- BEATS = ceil(DIM\*DIM / LANES). The final beat may be partial.
- Per-element rules, with a = latched element and MIN = -2^(W-1), MAX = 2^(W-1)-1:
  - op 0: result = -a, modulo 2^W. If a = MIN, result = MIN and `overflow` is set.
  - op 1: result = -a. If a = MIN, result = MAX and `overflow` is set.
  - op 2: result element (c,r) = a(r,c), where e = r\*DIM+c. `overflow` is never set.
  - op 3: p = a\*scalar as a full 2W-bit signed product, clamped to [MIN, MAX]. `overflow` is set if clamped.
- `result` and `overflow` hold their values from DONE until the next accepted `start`.

## Timing
- Reset values: state IDLE, `result` = 0, `busy` = 0, `done` = 0, `overflow` = 0, `idx` = 0.
- Reset takes effect on any cycle, including mid-RUN. A `start` asserted in the same cycle as `rst` is ignored.
- Start accepted on edge T0. `busy` is high for cycles T0+1 .. T0+BEATS, and `done` is high in cycle T0+BEATS+1.
- With defaults: BEATS = 5, so `done` arrives 6 cycles after accept.
- `result` is fully valid in the `done` cycle; partial updates are visible during RUN.
- Back-to-back: `start` in the `done` cycle is accepted. `busy` rises the next cycle with zero idle gap, and `result` clears at that accept.
- Throughput: one matrix per BEATS+1 cycles.

## Structure
- Shared package `matrix_pkg`:
  - `op` encodings: `OP_NEG`, `OP_NEG_SAT`, `OP_TRANSPOSE`, `OP_SCALE`.
  - Element MIN/MAX helper functions.
  - The packed-index function `(r*DIM+c)*W`, shared with the add/sub units.
- Sub-module `matrix_lane_alu`: one lane computing modes 0, 1 and 3 for a single element (negate/multiply plus saturation), with a per-lane overflow output. Instantiate it LANES times in a generate loop.
- The transpose index remap and the FSM live in the top module.

## Test plan
- Defaults, op 0, a(0,0) = 5, a(0,1) = -128, others 1 -> at the `done` pulse (cycle 6): r(0,0) = -5 (0xFB), r(0,1) = 0x80, others 0xFF; `overflow` = 1.
- op 1, same input -> r(0,1) = 127 (0x7F), `overflow` = 1. Repeat with no -128 present -> `overflow` = 0.
- op 2, a(r,c) = 10\*r+c -> r(r,c) = 10\*c+r for all r,c; r(1,3) = 31; `overflow` = 0.
- op 3, scalar = -3, a(2,2) = 50, a(0,0) = 7, others 0 -> r(2,2) = -128 (clamped from -150), r(0,0) = -21; `overflow` = 1.
- DIM = 5, LANES = 3 -> 9 beats, `done` 10 cycles after accept. Also: `start` held high through the DONE cycle is accepted immediately; `start` during `busy` is ignored.
- `rst` asserted at beat 2 of op 0 -> next cycle `busy` = 0, `result` = 0, `overflow` = 0, no `done`. A following `start` completes normally.
